// File: rtl/instr_memory_pkg.sv
// instr_memory_pkg: loader state encoding and default reset-vector base address
package instr_memory_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_SEALED  = 2'd2
    } load_state_e;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;
endpackage

// File: rtl/instr_memory_if.sv
// instr_memory_if: CPU fetch port plus byte-stream program loader port
//   instr_address/instr_readdata/fetch_fault : fetch side
//   load_valid/load_byte/load_ready/load_seal : loader handshake
interface instr_memory_if;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        fetch_fault;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_seal;
    modport master (
        output instr_address, load_valid, load_byte, load_seal,
        input  instr_readdata, fetch_fault, load_ready
    );
    modport slave (
        input  instr_address, load_valid, load_byte, load_seal,
        output instr_readdata, fetch_fault, load_ready
    );
endinterface

// File: rtl/instr_word_packer.sv
// instr_word_packer: assembles big-endian bytes into 32-bit words
//   clk, reset (async active-low)
//   accept      : a byte transfers this edge
//   load_byte   : the byte
//   seal        : seal this edge; flushes any partial word zero-padded
//   commit      : word ready to be written this edge
//   commit_word : full or padded word, including a byte accepted this edge
module instr_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [7:0]  load_byte,
    input  logic        seal,
    output logic        commit,
    output logic [31:0] commit_word
);
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    always_comb begin
        // byte_idx 0 lands in bits 31:24, so shift = 8*(3-idx) = {~idx,3'b0}
        commit_word = accept ? (asm_q | (32'(load_byte) << {~byte_idx_q, 3'b000})) : asm_q;
        // a byte accepted with the seal is folded in first; an empty word is never flushed
        commit      = (accept && byte_idx_q == 2'd3) || (seal && (accept || byte_idx_q != 2'd0));
        byte_idx_d  = commit ? 2'd0 : byte_idx_q + 2'(accept);
        asm_d       = commit ? 32'd0 : commit_word;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end
endmodule

// File: rtl/instr_memory.sv
// instr_memory: boot instruction memory filled once by a byte loader, then sealed
//   clk, reset (async active-low), clk_enable (gates loader only)
//   bus        : fetch and loader signals (slave side)
//   sealed     : program frozen
//   word_count : committed words
module instr_memory
    import instr_memory_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    instr_memory_if.slave          bus,
    output logic                   sealed,
    output logic [$clog2(DEPTH):0] word_count
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
    localparam logic [31:0] WIN_BYTES  = 32'(4 * DEPTH);

    load_state_e   state_q, state_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic [31:0]   mem_q [DEPTH];
    logic          accept, seal_go, commit, in_window;
    logic [31:0]   commit_word, offset;
    logic [AW-1:0] idx;

    instr_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .load_byte  (bus.load_byte),
        .seal       (seal_go),
        .commit     (commit),
        .commit_word(commit_word)
    );

    always_comb begin
        bus.load_ready = clk_enable && state_q != ST_SEALED && word_count_q < FULL_COUNT;
        accept         = bus.load_valid && bus.load_ready;
        seal_go        = clk_enable && bus.load_seal && state_q != ST_SEALED;
        state_d        = seal_go ? ST_SEALED :
                         (accept && state_q == ST_EMPTY) ? ST_LOADING : state_q;
        word_count_d   = word_count_q + {{AW{1'b0}}, commit};
        // addresses below the base wrap to large offsets and fall outside the window
        offset         = bus.instr_address - BASE_ADDR;
        in_window      = offset < WIN_BYTES;
        idx            = offset[AW+1:2];
        bus.fetch_fault    = in_window && bus.instr_address[1:0] != 2'b00;
        // word_count gating hides stale array contents after reset
        bus.instr_readdata = (in_window && !bus.fetch_fault && {1'b0, idx} < word_count_q) ?
                             mem_q[idx] : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
        end
    end

    // commit only occurs while word_count < DEPTH, so the index is always in range
    always_ff @(posedge clk) begin
        if (commit) mem_q[word_count_q[AW-1:0]] <= commit_word;
    end

    assign sealed     = state_q == ST_SEALED;
    assign word_count = word_count_q;
endmodule

// File: tb/tb_instr_memory.sv
// tb_instr_memory: directed and random checks against a byte-queue reference model
module tb_instr_memory;
    import instr_memory_pkg::*;
    localparam logic [31:0] BASE = DEFAULT_BASE_ADDR;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en0 = 1'b1;
    logic       en1 = 1'b1;
    logic       sealed0, sealed1;
    logic [6:0] wc0;
    logic [2:0] wc1;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         sl0 = 1'b0;
    bit         sl1 = 1'b0;

    instr_memory_if bus0();
    instr_memory_if bus1();

    instr_memory #(.BASE_ADDR(BASE), .DEPTH(64)) dut0 (
        .clk(clk), .reset(reset), .clk_enable(en0), .bus(bus0),
        .sealed(sealed0), .word_count(wc0)
    );
    instr_memory #(.BASE_ADDR(BASE), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .clk_enable(en1), .bus(bus1),
        .sealed(sealed1), .word_count(wc1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // reference model: accepted bytes in order plus a sealed flag
    function automatic int nb(int s); return s != 0 ? q1.size() : q0.size(); endfunction
    function automatic int dep(int s); return s != 0 ? 4 : 64; endfunction
    function automatic bit msl(int s); return s != 0 ? sl1 : sl0; endfunction
    function automatic int m_count(int s);
        return msl(s) ? (nb(s) + 3) / 4 : nb(s) / 4;
    endfunction
    function automatic logic [31:0] m_word(int s, int i);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            int j = 4 * i + k;
            logic [7:0] b = 8'h00;
            if (j < nb(s)) b = (s != 0) ? q1[j] : q0[j];
            w = (w << 8) | 32'(b);
        end
        return w;
    endfunction
    function automatic logic [31:0] m_read(int s, logic [31:0] a);
        logic [31:0] off = a - BASE;
        if (off >= 32'(4 * dep(s)) || a[1:0] != 2'b00) return 32'd0;
        return int'(off >> 2) < m_count(s) ? m_word(s, int'(off >> 2)) : 32'd0;
    endfunction
    function automatic logic m_fault(int s, logic [31:0] a);
        logic [31:0] off = a - BASE;
        return off < 32'(4 * dep(s)) && a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] o_rd(int s); return s != 0 ? bus1.instr_readdata : bus0.instr_readdata; endfunction
    function automatic logic o_fault(int s); return s != 0 ? bus1.fetch_fault : bus0.fetch_fault; endfunction
    function automatic logic o_rdy(int s); return s != 0 ? bus1.load_ready : bus0.load_ready; endfunction
    function automatic logic o_sealed(int s); return s != 0 ? sealed1 : sealed0; endfunction
    function automatic logic [31:0] o_wc(int s); return s != 0 ? 32'(wc1) : 32'(wc0); endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int s, logic v, logic [7:0] b, logic k, logic e);
        if (s != 0) begin
            bus1.load_valid = v; bus1.load_byte = b; bus1.load_seal = k; en1 = e;
        end else begin
            bus0.load_valid = v; bus0.load_byte = b; bus0.load_seal = k; en0 = e;
        end
    endtask

    // one loader cycle: drive, check ready, then advance the model at the edge
    task automatic cyc(int s, logic v, logic [7:0] b, logic k, logic e);
        bit can_take;
        @(negedge clk);
        drive(s, v, b, k, e);
        #1;
        can_take = e && !msl(s) && nb(s) < 4 * dep(s);
        check("load_ready", 32'(o_rdy(s)), 32'(can_take));
        @(posedge clk);
        if (e && !msl(s)) begin
            if (v && can_take) begin
                if (s != 0) q1.push_back(b); else q0.push_back(b);
            end
            if (k) begin
                if (s != 0) sl1 = 1'b1; else sl0 = 1'b1;
            end
        end
    endtask

    task automatic idle(int s);
        @(negedge clk);
        drive(s, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check("word_count", o_wc(s), 32'(m_count(s)));
        check("sealed", 32'(o_sealed(s)), 32'(msl(s)));
        check("idle_ready", 32'(o_rdy(s)), 32'(!msl(s) && nb(s) < 4 * dep(s)));
    endtask

    task automatic fetch(int s, logic [31:0] a);
        @(negedge clk);
        if (s != 0) bus1.instr_address = a; else bus0.instr_address = a;
        #1;
        check("readdata", o_rd(s), m_read(s, a));
        check("fetch_fault", 32'(o_fault(s)), 32'(m_fault(s, a)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1);
        bus0.instr_address = BASE;
        #2 reset = 1'b0;
        q0.delete(); q1.delete(); sl0 = 1'b0; sl1 = 1'b0;
        #1;
        check("rst_wc0", o_wc(0), 32'd0);
        check("rst_wc1", o_wc(1), 32'd0);
        check("rst_sealed0", 32'(sealed0), 32'd0);
        check("rst_read0", o_rd(0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0]  seq6 [6];
        logic [31:0] a;
        seq6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1);
        bus0.instr_address = 32'd0;
        bus1.instr_address = 32'd0;
        do_reset();
        idle(0);
        fetch(0, BASE);

        // single word then seal
        cyc(0, 1'b1, 8'h24, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h01, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h00, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h20, 1'b0, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(0);
        fetch(0, BASE);
        check("word0_const", o_rd(0), 32'h24010020);
        fetch(0, BASE + 32'd4);
        // sealed memory ignores further bytes and seals
        cyc(0, 1'b1, 8'h55, 1'b1, 1'b1);
        idle(0);
        fetch(0, BASE + 32'd4);

        // six bytes: second word zero-padded by the seal
        do_reset();
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, seq6[i], 1'b0, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(0);
        fetch(0, BASE);
        fetch(0, BASE + 32'd4);
        check("word1_const", o_rd(0), 32'h11220000);
        check("wc_two", o_wc(0), 32'd2);

        // fourth byte and seal in the same cycle
        do_reset();
        cyc(0, 1'b1, 8'h10, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h20, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h30, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h44, 1'b1, 1'b1);
        idle(0);
        check("same_cycle_wc", o_wc(0), 32'd1);
        check("same_cycle_sealed", 32'(sealed0), 32'd1);
        fetch(0, BASE);
        fetch(0, BASE + 32'd4);

        // second byte and seal in the same cycle pads the word
        do_reset();
        cyc(0, 1'b1, 8'h9A, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h5C, 1'b1, 1'b1);
        idle(0);
        fetch(0, BASE);
        check("pad_const", o_rd(0), 32'h9A5C0000);

        // clk_enable low blocks loading and sealing; then seal from EMPTY
        do_reset();
        cyc(0, 1'b1, 8'h77, 1'b1, 1'b0);
        idle(0);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(0);
        fetch(0, BASE);

        // misaligned and out-of-window fetches
        fetch(0, BASE + 32'd2);
        check("fault_const", 32'(bus0.fetch_fault), 32'd1);
        fetch(0, 32'd0);
        fetch(0, BASE + 32'd256);
        fetch(0, BASE - 32'd4);

        // DEPTH=4 fills after 16 bytes; remaining bytes are refused
        do_reset();
        for (int i = 1; i <= 20; i++) cyc(1, 1'b1, 8'(i), 1'b0, 1'b1);
        idle(1);
        check("full_wc", o_wc(1), 32'd4);
        check("full_ready", 32'(bus1.load_ready), 32'd0);
        for (int w = 0; w < 4; w++) fetch(1, BASE + 32'(4 * w));
        check("full_word3", o_rd(1), 32'h0D0E0F10);
        fetch(1, BASE + 32'd16);
        cyc(1, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(1);

        // reset mid-load discards progress
        do_reset();
        for (int i = 0; i < 11; i++) cyc(0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
        idle(0);
        fetch(0, BASE + 32'd4);
        fetch(0, BASE + 32'd8);
        do_reset();
        fetch(0, BASE);
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 8'(8'h31 + i), 1'b0, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(0);
        fetch(0, BASE);
        fetch(0, BASE + 32'd4);

        // random loading with clk_enable drops, fetches mid-load and after seal
        do_reset();
        repeat (120) cyc(0, $urandom % 4 != 0, 8'($urandom), 1'b0, $urandom % 6 != 0);
        idle(0);
        repeat (16) fetch(0, BASE + 32'(4 * $urandom_range(0, 63)));
        cyc(0, $urandom % 2 != 0, 8'($urandom), 1'b1, 1'b1);
        idle(0);
        repeat (32) begin
            case ($urandom % 4)
                0: a = BASE + 32'($urandom_range(0, 255));
                1: a = BASE + 32'(4 * $urandom_range(0, 63));
                2: a = 32'($urandom_range(0, 255));
                default: a = $urandom;
            endcase
            fetch(0, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
